// File: rtl/mdu_sequencer_if.sv
// MDU sequencer port bundle: E-stage op request in, HI/LO status out.
// The master drives the op; the slave is the sequencer.
interface mdu_sequencer_if;
  logic [3:0]  op_e;
  logic        flush_e;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        start_e;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rd_data;

  modport master (
    output op_e, flush_e, src_a, src_b,
    input  start_e, busy, hi, lo, rd_data
  );

  modport slave (
    input  op_e, flush_e, src_a, src_b,
    output start_e, busy, hi, lo, rd_data
  );
endinterface

// File: rtl/mdu_sequencer.sv
// Shared multiply/divide unit sequencer: fixed-latency busy window,
// HI/LO commit at the end, plus mthi/mtlo/mfhi/mflo service.
module mdu_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic        clk,
  input logic        rst_n,
  mdu_sequencer_if.slave mdu
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  localparam logic [3:0] MUL_N = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_N = 4'(DIV_CYCLES - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_n;
  logic [3:0]  count, count_n;
  logic        busy_q, busy_n;
  logic [31:0] hi_q, hi_n;
  logic [31:0] lo_q, lo_n;
  logic [31:0] pend_hi, pend_hi_n;
  logic [31:0] pend_lo, pend_lo_n;

  logic        is_mul, is_mulu, is_div, is_divu;
  logic        is_mthi, is_mtlo, live;
  logic [31:0] a, b;

  assign a       = mdu.src_a;
  assign b       = mdu.src_b;
  assign live    = !mdu.flush_e;
  assign is_mul  = mdu.op_e == OP_MULT;
  assign is_mulu = mdu.op_e == OP_MULTU;
  assign is_div  = mdu.op_e == OP_DIV;
  assign is_divu = mdu.op_e == OP_DIVU;
  assign is_mthi = mdu.op_e == OP_MTHI;
  assign is_mtlo = mdu.op_e == OP_MTLO;

  assign mdu.start_e =
    live & (is_mul | is_mulu | is_div | is_divu);

  logic [63:0] prod_s, prod_u;
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};

  // One unsigned divider serves both flavours; signed
  // results are rebuilt from magnitudes.
  logic [31:0] abs_a, abs_b, dvd, dvs;
  logic [31:0] uq, ur, sq, sr;
  logic        div_zero;

  assign abs_a    = a[31] ? -a : a;
  assign abs_b    = b[31] ? -b : b;
  assign div_zero = b == 32'd0;
  assign dvd      = is_div ? abs_a : a;
  assign dvs      = div_zero ? 32'd1 : (is_div ? abs_b : b);
  assign uq       = dvd / dvs;
  assign ur       = dvd % dvs;
  assign sq       = (a[31] ^ b[31]) ? -uq : uq;
  assign sr       = a[31] ? -ur : ur;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      count   <= 4'd0;
      busy_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
    end else begin
      state   <= state_n;
      count   <= count_n;
      busy_q  <= busy_n;
      hi_q    <= hi_n;
      lo_q    <= lo_n;
      pend_hi <= pend_hi_n;
      pend_lo <= pend_lo_n;
    end
  end

  always_comb begin
    state_n   = state;
    count_n   = count;
    busy_n    = busy_q;
    hi_n      = hi_q;
    lo_n      = lo_q;
    pend_hi_n = pend_hi;
    pend_lo_n = pend_lo;
    unique case (state)
      IDLE: begin
        if (live) begin
          unique case (1'b1)
            is_mul: begin
              {pend_hi_n, pend_lo_n} = prod_s;
              count_n = MUL_N;
              busy_n  = 1'b1;
              state_n = RUN;
            end
            is_mulu: begin
              {pend_hi_n, pend_lo_n} = prod_u;
              count_n = MUL_N;
              busy_n  = 1'b1;
              state_n = RUN;
            end
            is_div, is_divu: begin
              // A zero divisor commits the old HI/LO back.
              pend_hi_n = div_zero ? hi_q
                        : (is_div ? sr : ur);
              pend_lo_n = div_zero ? lo_q
                        : (is_div ? sq : uq);
              count_n = DIV_N;
              busy_n  = 1'b1;
              state_n = RUN;
            end
            is_mthi: hi_n = a;
            is_mtlo: lo_n = a;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (count == 4'd0) begin
          hi_n    = pend_hi;
          lo_n    = pend_lo;
          busy_n  = 1'b0;
          state_n = IDLE;
        end else begin
          count_n = count - 4'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign mdu.busy = busy_q;
  assign mdu.hi   = hi_q;
  assign mdu.lo   = lo_q;

  assign mdu.rd_data =
    (mdu.op_e == OP_MFHI) ? hi_q :
    (mdu.op_e == OP_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Random + directed bench for mdu_sequencer against a
// cycle-indexed behavioural model of HI/LO and the busy window.
module tb_mdu_sequencer;

  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mdu_sequencer_if bus ();

  mdu_sequencer #(
    .MULT_CYCLES(MC),
    .DIV_CYCLES (DC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .mdu  (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // model: edge index, commit edge (-1 = idle), results
  int          cyc = 0;
  int          done = -1;
  logic [31:0] m_hi = 0, m_lo = 0;
  logic [31:0] r_hi, r_lo;
  bit          r_dz;
  int          busy_seen;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic void ref_op(
    input int op, input logic [31:0] a, b,
    output logic [31:0] rh, rl, output bit dz);
    logic [63:0] p;
    longint la, lb, q, r;
    int sa, sb;
    dz = 0;
    rh = 0;
    rl = 0;
    case (op)
      1: begin
        sa = a; sb = b;
        la = sa; lb = sb;
        p = la * lb;
        {rh, rl} = p;
      end
      2: begin
        p = {32'd0, a} * {32'd0, b};
        {rh, rl} = p;
      end
      3: begin
        if (b == 0) dz = 1;
        else begin
          sa = a; sb = b;
          la = sa; lb = sb;
          q = la / lb;
          r = la % lb;
          rl = q[31:0];
          rh = r[31:0];
        end
      end
      4: begin
        if (b == 0) dz = 1;
        else begin
          rl = a / b;
          rh = a % b;
        end
      end
      default: ;
    endcase
  endfunction

  task automatic cycle(input int op, input bit fl,
                       input logic [31:0] a, b);
    logic [31:0] exp_rd;
    bit st;
    bus.op_e    = 4'(op);
    bus.flush_e = fl;
    bus.src_a   = a;
    bus.src_b   = b;
    #1;
    st = (op >= 1 && op <= 4) && !fl;
    exp_rd = op == 7 ? m_hi : op == 8 ? m_lo : 32'd0;
    chk("start_e", {31'd0, bus.start_e}, {31'd0, st});
    chk("rd_data", bus.rd_data, exp_rd);
    @(posedge clk);
    cyc++;
    if (done >= 0) begin
      if (cyc == done) begin
        if (!r_dz) begin
          m_hi = r_hi;
          m_lo = r_lo;
        end
        done = -1;
      end
    end else if (!fl) begin
      if (op >= 1 && op <= 4) begin
        ref_op(op, a, b, r_hi, r_lo, r_dz);
        done = cyc + ((op <= 2) ? MC : DC);
      end else if (op == 5) m_hi = a;
      else if (op == 6) m_lo = a;
    end
    #1;
    if (bus.busy) busy_seen++;
    chk("busy", {31'd0, bus.busy}, {31'd0, done >= 0});
    chk("hi", bus.hi, m_hi);
    chk("lo", bus.lo, m_lo);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && done >= 0; i++)
      cycle(0, 0, $urandom, $urandom);
  endtask

  initial begin
    bus.op_e = 0;
    bus.flush_e = 0;
    bus.src_a = 0;
    bus.src_b = 0;
    rst_n = 0;
    #12;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    @(negedge clk);
    rst_n = 1;

    busy_seen = 0;
    cycle(1, 0, 32'hFFFFFFFF, 32'd2);
    drain();
    chk("mult_busy_n", busy_seen, MC);
    chk("mult_hi", bus.hi, 32'hFFFFFFFF);
    chk("mult_lo", bus.lo, 32'hFFFFFFFE);

    cycle(2, 0, 32'hFFFFFFFF, 32'd2);
    drain();
    chk("multu_hi", bus.hi, 32'h00000001);
    chk("multu_lo", bus.lo, 32'hFFFFFFFE);

    busy_seen = 0;
    cycle(3, 0, -32'sd7, 32'd2);
    drain();
    chk("div_busy_n", busy_seen, DC);
    chk("div_hi", bus.hi, 32'hFFFFFFFF);
    chk("div_lo", bus.lo, 32'hFFFFFFFD);

    cycle(3, 0, 32'h80000000, 32'hFFFFFFFF);
    drain();
    chk("ovf_hi", bus.hi, 32'h0);
    chk("ovf_lo", bus.lo, 32'h80000000);

    cycle(5, 0, 32'h12345678, 0);
    cycle(6, 0, 32'h12345678, 0);
    busy_seen = 0;
    cycle(4, 0, 32'd5, 32'd0);
    drain();
    chk("dz_busy_n", busy_seen, DC);
    chk("dz_hi", bus.hi, 32'h12345678);
    chk("dz_lo", bus.lo, 32'h12345678);

    busy_seen = 0;
    cycle(1, 1, 32'd3, 32'd4);
    cycle(5, 1, 32'hA5A5A5A5, 0);
    cycle(0, 0, 0, 0);
    chk("flush_busy_n", busy_seen, 0);
    chk("flush_hi", bus.hi, 32'h12345678);

    // op during RUN is dropped; back-to-back mfhi after busy falls
    cycle(2, 0, 32'd6, 32'd7);
    cycle(6, 0, 32'hDEADBEEF, 0);
    cycle(1, 0, 32'd9, 32'd9);
    drain();
    cycle(7, 0, 0, 0);
    chk("b2b_lo", bus.lo, 32'd42);

    cycle(3, 0, 32'd100, 32'd7);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    #2;
    rst_n = 0;
    #1;
    chk("arst_busy", {31'd0, bus.busy}, 32'd0);
    chk("arst_hi", bus.hi, 32'd0);
    chk("arst_lo", bus.lo, 32'd0);
    m_hi = 0;
    m_lo = 0;
    done = -1;
    @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < 400; i++) begin
      logic [31:0] a, b;
      int sel;
      a = $urandom;
      b = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) b = 0;
      if (sel == 1) begin
        a = 32'h80000000;
        b = 32'hFFFFFFFF;
      end
      if (sel == 2) b = $urandom_range(1, 9);
      cycle($urandom_range(0, 8),
            ($urandom_range(0, 4) == 0), a, b);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
